// File: rtl/bc_disp_pkg.sv
// Shared display definitions for the Bulls & Cows game and its display stage.
// Holds the 6-bit display codes, the blank segment pattern and the glyph
// decode function (6-bit code -> active-low {g,f,e,d,c,b,a}).
package bc_disp_pkg;

    localparam int unsigned CODE_W     = 6;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;

    localparam logic [CODE_W-1:0] CODE_P     = 6'h0A;
    localparam logic [CODE_W-1:0] CODE_B     = 6'h0B;
    localparam logic [CODE_W-1:0] CODE_C     = 6'h0C;
    localparam logic [CODE_W-1:0] CODE_S     = 6'h0D;
    localparam logic [CODE_W-1:0] CODE_E     = 6'h0E;
    localparam logic [CODE_W-1:0] CODE_U     = 6'h0F;
    localparam logic [CODE_W-1:0] CODE_DASH  = 6'h10;
    localparam logic [CODE_W-1:0] CODE_BLANK = 6'h3F;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Active-low segment pattern for a display code; unknown codes are blank.
    function automatic logic [SEG_W-1:0] glyph(input logic [CODE_W-1:0] code);
        logic [SEG_W-1:0] g;
        g = SEG_BLANK;
        case (code)
            6'h00:      g = 7'h40;
            6'h01:      g = 7'h79;
            6'h02:      g = 7'h24;
            6'h03:      g = 7'h30;
            6'h04:      g = 7'h19;
            6'h05:      g = 7'h12;
            6'h06:      g = 7'h02;
            6'h07:      g = 7'h78;
            6'h08:      g = 7'h00;
            6'h09:      g = 7'h10;
            CODE_P:     g = 7'h0C;
            CODE_B:     g = 7'h03;
            CODE_C:     g = 7'h27;
            CODE_S:     g = 7'h12;
            CODE_E:     g = 7'h06;
            CODE_U:     g = 7'h41;
            CODE_DASH:  g = 7'h3F;
            CODE_BLANK: g = SEG_BLANK;
            default:    g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_glyph_decoder.sv
// Combinational glyph decoder.
// Ports:
//   code  - 6-bit display code
//   seg_c - active-low segments {g,f,e,d,c,b,a}
module seg7_glyph_decoder
    import bc_disp_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  seg_c
);

    assign seg_c = glyph(code);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment driver.
// Scans position 0 (d8) through position 7 (d1), DIGIT_CYCLES clocks each,
// with DEAD_CYCLES of all-anodes-off at the start of every slot. Codes are
// snapshotted once per frame so a frame never mixes old and new values.
// While either win flag is high the anodes blink with a half-period of
// BLINK_FRAMES frames; the winner's end digit lights its decimal point.
// DIGIT_CYCLES must exceed DEAD_CYCLES.
// Ports:
//   clock, reset         - clock, synchronous active-high reset
//   d1..d8               - display codes, d1 leftmost (position 7)
//   p1_win, p2_win       - win levels from the game FSM
//   an                   - anodes, active-low, an[k] = position k
//   seg                  - segments {g,f,e,d,c,b,a}, active-low
//   dp                   - decimal point, active-low
//   frame_tick           - one-cycle pulse at each frame start
module seg7_scan_driver
    import bc_disp_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned DEAD_CYCLES  = 100,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CODE_W-1:0] d1,
    input  logic [CODE_W-1:0] d2,
    input  logic [CODE_W-1:0] d3,
    input  logic [CODE_W-1:0] d4,
    input  logic [CODE_W-1:0] d5,
    input  logic [CODE_W-1:0] d6,
    input  logic [CODE_W-1:0] d7,
    input  logic [CODE_W-1:0] d8,
    input  logic              p1_win,
    input  logic              p2_win,
    output logic [7:0]        an,
    output logic [SEG_W-1:0]  seg,
    output logic              dp,
    output logic              frame_tick
);

    localparam int unsigned CNT_W   = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_DEAD   = CNT_W'(DEAD_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic [CODE_W-1:0]  snap [NUM_DIGITS];
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    logic               slot_end_c;
    logic               frame_end_c;
    logic               win_c;
    logic [CODE_W-1:0]  code_by_pos_c [NUM_DIGITS];
    logic [SEG_W-1:0]   seg_next_c;
    logic [7:0]         an_next_c;
    logic               dp_next_c;
    logic [BLINK_W-1:0] blink_cnt_next_c;
    logic               blink_phase_next_c;

    assign slot_end_c  = (cnt == CNT_LAST);
    assign frame_end_c = slot_end_c && (idx == IDX_LAST);
    assign win_c       = p1_win | p2_win;

    // Position k shows d(8-k): d8 is the rightmost digit.
    always_comb begin
        code_by_pos_c[0] = d8;
        code_by_pos_c[1] = d7;
        code_by_pos_c[2] = d6;
        code_by_pos_c[3] = d5;
        code_by_pos_c[4] = d4;
        code_by_pos_c[5] = d3;
        code_by_pos_c[6] = d2;
        code_by_pos_c[7] = d1;
    end

    seg7_glyph_decoder u_decoder (
        .code  (snap[idx]),
        .seg_c (seg_next_c)
    );

    // Anode and decimal point for the slot currently being scanned.
    always_comb begin
        an_next_c = 8'hFF;
        if ((cnt >= CNT_DEAD) && !blink_phase) begin
            an_next_c[idx] = 1'b0;
        end
        dp_next_c = ~(((idx == IDX_LAST) && p1_win) ||
                      ((idx == IDX_W'(0)) && p2_win));
    end

    // Blink counter advances per frame while won; clears at once otherwise.
    always_comb begin
        blink_cnt_next_c   = blink_cnt;
        blink_phase_next_c = blink_phase;
        if (!win_c) begin
            blink_cnt_next_c   = '0;
            blink_phase_next_c = 1'b0;
        end else if (frame_end_c) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next_c   = '0;
                blink_phase_next_c = ~blink_phase;
            end else begin
                blink_cnt_next_c = blink_cnt + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            an          <= 8'hFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_tick  <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                snap[k] <= CODE_BLANK;
            end
        end else begin
            cnt         <= slot_end_c ? '0 : cnt + CNT_W'(1);
            idx         <= slot_end_c ? idx + IDX_W'(1) : idx;
            blink_cnt   <= blink_cnt_next_c;
            blink_phase <= blink_phase_next_c;
            an          <= an_next_c;
            seg         <= seg_next_c;
            dp          <= dp_next_c;
            frame_tick  <= frame_end_c;
            if (frame_end_c) begin
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    snap[k] <= code_by_pos_c[k];
                end
            end
        end
    end

endmodule
